// File: rtl/ft2232_tx_mux_pkg.sv
// Shared definitions for the FT2232 transmit multiplexer.
//   state_e          : 2-bit FSM state encoding
//   HDR_TAG_DEFAULT  : default upper nibble of every header byte
//   len_decode()     : maps a length byte to a payload count (0 means 256)
package ft2232_tx_mux_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned REM_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    // A zero length byte stands for a full 256-byte payload.
    function automatic logic [REM_W-1:0] len_decode(input logic [BYTE_W-1:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/ft2232_tx_mux_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index where the search starts
//   gnt_o : one-hot grant (zero when nothing requests)
//   idx_o : index of the granted requester
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_w;
    logic             found;

    // Scan from ptr upwards with wrap; first requester wins.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = 0;
        cand_w = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_w = IDX_W'(cand);
            if (!found && req_i[cand_w]) begin
                found         = 1'b1;
                gnt_o[cand_w] = 1'b1;
                idx_o         = cand_w;
            end
        end
    end

endmodule

// File: rtl/ft2232_tx_mux.sv
// Multiplexes N_SRC packet sources onto one FT2232 byte stream.
// Each packet goes out as header {HDR_TAG, index}, length byte, payload.
//   clk_i, reset_i : clock, synchronous active-high reset
//   src_*          : per-source request, length, data, valid, ready
//   out_data_o/out_req_o/out_ack_i : byte handshake towards the FT2232 side
//   grant_o        : one-hot current owner, busy_o : not idle
module ft2232_tx_mux
    import ft2232_tx_mux_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter logic [3:0]  HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [N_SRC-1:0]     src_req_i,
    input  logic [8*N_SRC-1:0]   src_len_i,
    input  logic [8*N_SRC-1:0]   src_data_i,
    input  logic [N_SRC-1:0]     src_valid_i,
    output logic [N_SRC-1:0]     src_ready_o,
    output logic [7:0]           out_data_o,
    output logic                 out_req_o,
    input  logic                 out_ack_i,
    output logic [N_SRC-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic [7:0]         len_q, len_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               ack_seen_q, ack_seen_d;

    logic [N_SRC-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [7:0]         cur_data;
    logic               cur_valid;
    logic [7:0]         arb_len;
    logic               req_c;
    logic               xfer;

    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (src_req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Byte-lane selects; {idx, 3'b000} is exactly idx*8 at the needed width.
    assign cur_data  = src_data_i[{g_q, 3'b000} +: 8];
    assign cur_valid = src_valid_i[g_q];
    assign arb_len   = src_len_i[{arb_idx, 3'b000} +: 8];

    // Request drops for one cycle after every transfer; payload also needs valid.
    assign req_c = (state_q != ST_IDLE) && !ack_seen_q &&
                   ((state_q != ST_DATA) || cur_valid);
    assign xfer  = req_c && out_ack_i;

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        grant_d    = grant_q;
        len_d      = len_q;
        rem_d      = rem_q;
        ack_seen_d = xfer;
        case (state_q)
            ST_IDLE: begin
                if (|src_req_i) begin
                    grant_d = arb_gnt;
                    g_d     = arb_idx;
                    len_d   = arb_len;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    rem_d   = len_decode(len_q);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = (g_q == IDX_W'(N_SRC - 1)) ? '0 : g_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            grant_q    <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    // Output decode.
    always_comb begin
        out_data_o  = 8'd0;
        src_ready_o = '0;
        case (state_q)
            ST_HDR:  out_data_o = {HDR_TAG, 4'(g_q)};
            ST_LEN:  out_data_o = len_q;
            ST_DATA: begin
                out_data_o = cur_data;
                if (xfer) begin
                    src_ready_o = grant_q;
                end
            end
            default: out_data_o = 8'd0;
        endcase
    end

    assign out_req_o = req_c;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
